scsi_port_arb: RTL and testbench
================================

SCSI_PORT_ARB -- requirements
Module: scsi_port_arb

Interface
REQ-001 SHALL have parameter STROBE_CYC, default 3, strobe width in clocks (legal 1..7).
REQ-002 SHALL have ports:
- nCPUCLK  in  1  sole clock; all state changes on rising edge.
- RST  in  1  asynchronous active-high reset.
- CPU_REQ  in  1  qualified CPU register cycle to WD33C93 (AS_/DMAC_/WDREGREQ decoded upstream).
- CPU_RW  in  1  1 = CPU read, 0 = CPU write; sampled at grant.
- DMA_EN  in  1  DMA engine enabled.
- DREQ  in  1  WD33C93 data request.
- DMA_DIR  in  1  1 = chip-to-FIFO, 0 = FIFO-to-chip.
- FIFO_FULL  in  1  FIFO full.
- FIFO_EMPTY  in  1  FIFO empty.
- SCSI_CS_  out  1  chip select, active low.
- SCSI_RE_  out  1  read strobe, active low.
- SCSI_WE_  out  1  write strobe, active low.
- DACK_  out  1  DMA acknowledge, active low.
- CPU_TERM_  out  1  register-cycle termination to CPU, active low.
- CPU_LE  out  1  one-clock CPU read-data latch pulse.
- FIFO_PUSH  out  1  one-clock FIFO write pulse.
- FIFO_POP  out  1  one-clock FIFO read pulse.
- OWNER  out  1  last granted owner, 1 = CPU.

Function
REQ-003 SHALL be a registered FSM, states IDLE, CPU_SETUP, CPU_STROBE, CPU_HOLD, CPU_TERM, DMA_SETUP, DMA_STROBE, DMA_HOLD.
REQ-004 SHALL define dma_ok = DMA_EN & DREQ & (DMA_DIR ? ~FIFO_FULL : ~FIFO_EMPTY).
REQ-005 IDLE: CPU_REQ only -> CPU_SETUP; dma_ok only -> DMA_SETUP; both -> side not equal to OWNER (alternating); neither -> stay.
REQ-006 OWNER SHALL update on the grant edge.
REQ-007 SETUP states SHALL last 1 clock with SCSI_CS_ low, strobes high.
REQ-008 STROBE states SHALL last exactly STROBE_CYC clocks, tracked by 3-bit counter cleared on entry; CS_ low; RE_ low if read (CPU_RW=1 or DMA_DIR=1), else WE_ low.
REQ-009 HOLD states SHALL last 1 clock, CS_ low, strobes high.
REQ-010 DACK_ SHALL be low throughout DMA_SETUP, DMA_STROBE, DMA_HOLD only.
REQ-011 CPU_LE SHALL pulse on final CPU_STROBE clock of a read; FIFO_PUSH on final DMA_STROBE clock when DMA_DIR=1.
REQ-012 FIFO_POP SHALL pulse in the DMA_SETUP clock when DMA_DIR=0.
REQ-013 CPU_HOLD -> CPU_TERM; CPU_TERM SHALL hold CPU_TERM_ low until CPU_REQ low, then -> IDLE with CPU_TERM_ high next clock.
REQ-014 DMA_HOLD -> IDLE; one transfer per grant, minimum 1 IDLE clock between grants.
REQ-015 CPU_REQ falling in CPU_SETUP SHALL -> IDLE; in CPU_STROBE SHALL -> CPU_HOLD next clock then IDLE; CPU_TERM_ SHALL not assert; CPU_LE SHALL not pulse.
REQ-016 DMA_EN, DREQ or FIFO flag changes after grant SHALL NOT abort a DMA transfer.
REQ-017 All outputs SHALL be registered, glitch-free.

Reset
REQ-018 RST high SHALL force IDLE, counter 0, OWNER=0, all active-low outputs 1, all pulses 0, within same clock, including mid-transfer.
REQ-019 First grant after reset with both pending SHALL go to CPU.

Structure
REQ-020 State encoding and STROBE_CYC default SHALL live in shared package sdmac_pkg.
REQ-021 Strobe-width counter SHALL be sub-module strobe_timer (load, count, done).

Verification
REQ-022 CPU read, STROBE_CYC=3: CPU_REQ high -> CS_ low 6 clocks, RE_ low 3, CPU_LE 1 pulse, CPU_TERM_ low until CPU_REQ drops.
REQ-023 DMA_DIR=1, DREQ steady, FIFO not full: -> DACK_ low 5 clocks/transfer, FIFO_PUSH 1 per transfer, 1 idle clock between; FIFO_FULL high -> no further grants.
REQ-024 CPU_REQ and dma_ok together from reset -> CPU, DMA, CPU order; OWNER toggles 1,0,1.
REQ-025 CPU_REQ drops on 2nd CPU_STROBE clock -> 1 CPU_HOLD clock, IDLE, CPU_TERM_ never low, no CPU_LE.
REQ-026 RST pulsed during DMA_STROBE -> all strobes high, DACK_ high immediately, no FIFO_PUSH.

Source files
------------

// File: rtl/sdmac_pkg.sv
// rtl/sdmac_pkg.sv - shared state encoding and strobe-width default for the SCSI port arbiter
package sdmac_pkg;

  // Default width of the RE_/WE_ strobe in clocks (legal range 1..7)
  localparam int STROBE_CYC_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CPU_SETUP  = 3'd1,
    CPU_STROBE = 3'd2,
    CPU_HOLD   = 3'd3,
    CPU_TERM   = 3'd4,
    DMA_SETUP  = 3'd5,
    DMA_STROBE = 3'd6,
    DMA_HOLD   = 3'd7
  } arb_state_t;

endpackage

// File: rtl/strobe_timer.sv
// rtl/strobe_timer.sv - 3-bit strobe-width counter
//
// Purpose: counts the clocks spent in a strobe state.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   load  - clear the count (asserted in the setup clock before a strobe)
//   count - advance the count (asserted while strobing)
//   cnt   - current strobe clock index, 0 on the first strobe clock
//   done  - current clock is the final strobe clock
module strobe_timer
  import sdmac_pkg::*;
#(
  parameter int STROBE_CYC = STROBE_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       count,
  output logic [2:0] cnt,
  output logic       done
);

  localparam logic [2:0] LAST = 3'(STROBE_CYC - 1);

  assign done = (cnt == LAST);

  // Wrap back to zero after the final clock so the counter idles at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= 3'd0;
    end else if (count) begin
      cnt <= done ? 3'd0 : cnt + 3'd1;
    end
  end

endmodule

// File: rtl/scsi_port_arb.sv
// rtl/scsi_port_arb.sv - CPU/DMA arbiter and strobe generator for the WD33C93 port
//
// Purpose: grants the SCSI chip bus to either a CPU register cycle or one DMA
// transfer, alternating when both are pending, and generates CS_/RE_/WE_/DACK_
// timing plus CPU termination and FIFO handshake pulses.
// Ports:
//   nCPUCLK    - clock, all state changes on rising edge
//   RST        - asynchronous active-high reset
//   CPU_REQ    - qualified CPU register cycle request
//   CPU_RW     - 1 = CPU read, 0 = CPU write, sampled at grant
//   DMA_EN     - DMA engine enabled
//   DREQ       - chip data request
//   DMA_DIR    - 1 = chip-to-FIFO, 0 = FIFO-to-chip, sampled at grant
//   FIFO_FULL  - FIFO full
//   FIFO_EMPTY - FIFO empty
//   SCSI_CS_   - chip select, active low
//   SCSI_RE_   - read strobe, active low
//   SCSI_WE_   - write strobe, active low
//   DACK_      - DMA acknowledge, active low
//   CPU_TERM_  - CPU cycle termination, active low
//   CPU_LE     - CPU read-data latch pulse
//   FIFO_PUSH  - FIFO write pulse
//   FIFO_POP   - FIFO read pulse
//   OWNER      - last granted owner, 1 = CPU
module scsi_port_arb
  import sdmac_pkg::*;
#(
  parameter int STROBE_CYC = STROBE_CYC_DEFAULT
) (
  input  logic nCPUCLK,
  input  logic RST,
  input  logic CPU_REQ,
  input  logic CPU_RW,
  input  logic DMA_EN,
  input  logic DREQ,
  input  logic DMA_DIR,
  input  logic FIFO_FULL,
  input  logic FIFO_EMPTY,
  output logic SCSI_CS_,
  output logic SCSI_RE_,
  output logic SCSI_WE_,
  output logic DACK_,
  output logic CPU_TERM_,
  output logic CPU_LE,
  output logic FIFO_PUSH,
  output logic FIFO_POP,
  output logic OWNER
);

  localparam logic [2:0] LAST = 3'(STROBE_CYC - 1);

  arb_state_t state, next_state;
  logic       rw_q, dir_q, abort_q, abort_d;
  logic       grant_cpu, grant_dma;
  logic       dma_ok;
  logic       in_setup, in_strobe, last_next;
  logic [2:0] cnt, cnt_inc;
  logic       done;
  logic       cs_n_d, re_n_d, we_n_d, dack_n_d, term_n_d;
  logic       le_d, push_d, pop_d;

  assign dma_ok    = DMA_EN & DREQ & (DMA_DIR ? ~FIFO_FULL : ~FIFO_EMPTY);
  assign in_setup  = (state == CPU_SETUP) || (state == DMA_SETUP);
  assign in_strobe = (state == CPU_STROBE) || (state == DMA_STROBE);
  assign cnt_inc   = cnt + 3'd1;

  strobe_timer #(.STROBE_CYC(STROBE_CYC)) u_timer (
    .clk   (nCPUCLK),
    .rst   (RST),
    .load  (in_setup),
    .count (in_strobe),
    .cnt   (cnt),
    .done  (done)
  );

  // Outputs are registered from the next state, so the pulses need to know
  // whether the coming clock will be the final strobe clock.
  assign last_next = (in_setup && (STROBE_CYC == 1)) ||
                     (in_strobe && !done && (cnt_inc == LAST));

  always_comb begin
    next_state = state;
    grant_cpu  = 1'b0;
    grant_dma  = 1'b0;
    abort_d    = abort_q;
    case (state)
      IDLE: begin
        abort_d = 1'b0;
        // With both pending, CPU wins only when DMA owned the last grant
        if (CPU_REQ && (!dma_ok || !OWNER)) begin
          next_state = CPU_SETUP;
          grant_cpu  = 1'b1;
        end else if (dma_ok) begin
          next_state = DMA_SETUP;
          grant_dma  = 1'b1;
        end
      end
      CPU_SETUP:  next_state = CPU_REQ ? CPU_STROBE : IDLE;
      CPU_STROBE: begin
        if (!CPU_REQ) begin
          next_state = CPU_HOLD;
          abort_d    = 1'b1;
        end else if (done) begin
          next_state = CPU_HOLD;
        end
      end
      CPU_HOLD:   next_state = abort_q ? IDLE : CPU_TERM;
      CPU_TERM:   if (!CPU_REQ) next_state = IDLE;
      DMA_SETUP:  next_state = DMA_STROBE;
      DMA_STROBE: if (done) next_state = DMA_HOLD;
      DMA_HOLD:   next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    cs_n_d   = (next_state == IDLE);
    re_n_d   = 1'b1;
    we_n_d   = 1'b1;
    dack_n_d = !((next_state == DMA_SETUP) || (next_state == DMA_STROBE) ||
                 (next_state == DMA_HOLD));
    term_n_d = (next_state != CPU_TERM);
    le_d     = 1'b0;
    push_d   = 1'b0;
    // Direction is live at the grant edge, latched afterwards
    pop_d    = grant_dma && !DMA_DIR;
    if (next_state == CPU_STROBE) begin
      if (rw_q) re_n_d = 1'b0;
      else      we_n_d = 1'b0;
      le_d = rw_q && last_next;
    end
    if (next_state == DMA_STROBE) begin
      if (dir_q) re_n_d = 1'b0;
      else       we_n_d = 1'b0;
      push_d = dir_q && last_next;
    end
  end

  always_ff @(posedge nCPUCLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      OWNER     <= 1'b0;
      rw_q      <= 1'b0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      SCSI_CS_  <= 1'b1;
      SCSI_RE_  <= 1'b1;
      SCSI_WE_  <= 1'b1;
      DACK_     <= 1'b1;
      CPU_TERM_ <= 1'b1;
      CPU_LE    <= 1'b0;
      FIFO_PUSH <= 1'b0;
      FIFO_POP  <= 1'b0;
    end else begin
      state   <= next_state;
      abort_q <= abort_d;
      if (grant_cpu) begin
        OWNER <= 1'b1;
        rw_q  <= CPU_RW;
      end
      if (grant_dma) begin
        OWNER <= 1'b0;
        dir_q <= DMA_DIR;
      end
      SCSI_CS_  <= cs_n_d;
      SCSI_RE_  <= re_n_d;
      SCSI_WE_  <= we_n_d;
      DACK_     <= dack_n_d;
      CPU_TERM_ <= term_n_d;
      CPU_LE    <= le_d;
      FIFO_PUSH <= push_d;
      FIFO_POP  <= pop_d;
    end
  end

endmodule

// File: tb/tb_scsi_port_arb.sv
// tb/tb_scsi_port_arb.sv - directed self-checking bench for scsi_port_arb
module tb_scsi_port_arb;

  logic nCPUCLK = 1'b0;
  logic RST;
  logic CPU_REQ, CPU_RW, DMA_EN, DREQ, DMA_DIR, FIFO_FULL, FIFO_EMPTY;
  logic SCSI_CS_, SCSI_RE_, SCSI_WE_, DACK_, CPU_TERM_;
  logic CPU_LE, FIFO_PUSH, FIFO_POP, OWNER;

  int checks = 0;
  int failures = 0;

  always #5 nCPUCLK = ~nCPUCLK;

  scsi_port_arb #(.STROBE_CYC(3)) dut (
    .nCPUCLK    (nCPUCLK),
    .RST        (RST),
    .CPU_REQ    (CPU_REQ),
    .CPU_RW     (CPU_RW),
    .DMA_EN     (DMA_EN),
    .DREQ       (DREQ),
    .DMA_DIR    (DMA_DIR),
    .FIFO_FULL  (FIFO_FULL),
    .FIFO_EMPTY (FIFO_EMPTY),
    .SCSI_CS_   (SCSI_CS_),
    .SCSI_RE_   (SCSI_RE_),
    .SCSI_WE_   (SCSI_WE_),
    .DACK_      (DACK_),
    .CPU_TERM_  (CPU_TERM_),
    .CPU_LE     (CPU_LE),
    .FIFO_PUSH  (FIFO_PUSH),
    .FIFO_POP   (FIFO_POP),
    .OWNER      (OWNER)
  );

  function automatic logic [8:0] outs();
    return {SCSI_CS_, SCSI_RE_, SCSI_WE_, DACK_, CPU_TERM_, CPU_LE, FIFO_PUSH, FIFO_POP, OWNER};
  endfunction

  task automatic tick();
    @(posedge nCPUCLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    CPU_REQ = 0; CPU_RW = 0; DMA_EN = 0; DREQ = 0; DMA_DIR = 0;
    FIFO_FULL = 0; FIFO_EMPTY = 1;
    tick(); tick();
    checks++;
    if (outs() !== 9'b111110000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", outs(), 9'b111110000);
    end
    RST = 1'b0;
    tick(); tick();
    checks++;
    if (outs() !== 9'b111110000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=%b", outs(), 9'b111110000);
    end
  endtask

  task automatic test_cpu_read();
    int cs_n = 0, re_n = 0, we_n = 0, le_n = 0, le_re = 0, term_n = 0;
    logic [1:0] first;
    CPU_RW = 1'b1;
    CPU_REQ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) first = {SCSI_CS_, SCSI_RE_};
      if (!SCSI_CS_) cs_n++;
      if (!SCSI_RE_) re_n++;
      if (!SCSI_WE_) we_n++;
      if (CPU_LE) le_n++;
      if (CPU_LE && !SCSI_RE_) le_re++;
      if (!CPU_TERM_) begin
        term_n++;
        CPU_REQ = 1'b0;
      end
    end
    checks++;
    if (first !== 2'b01) begin failures++; $display("FAIL rd_setup_cs_re got=%b exp=01", first); end
    checks++;
    if (cs_n !== 6) begin failures++; $display("FAIL rd_cs_clocks got=%0d exp=6", cs_n); end
    checks++;
    if (re_n !== 3) begin failures++; $display("FAIL rd_re_clocks got=%0d exp=3", re_n); end
    checks++;
    if (we_n !== 0) begin failures++; $display("FAIL rd_we_clocks got=%0d exp=0", we_n); end
    checks++;
    if (le_n !== 1 || le_re !== 1) begin
      failures++; $display("FAIL rd_cpu_le got=%0d/%0d exp=1/1", le_n, le_re);
    end
    checks++;
    if (term_n !== 1) begin failures++; $display("FAIL rd_term_clocks got=%0d exp=1", term_n); end
    checks++;
    if (OWNER !== 1'b1) begin failures++; $display("FAIL rd_owner got=%b exp=1", OWNER); end
  endtask

  task automatic test_cpu_write();
    int re_n = 0, we_n = 0, le_n = 0;
    CPU_RW = 1'b0;
    CPU_REQ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!SCSI_RE_) re_n++;
      if (!SCSI_WE_) we_n++;
      if (CPU_LE) le_n++;
      if (!CPU_TERM_) CPU_REQ = 1'b0;
    end
    checks++;
    if (we_n !== 3) begin failures++; $display("FAIL wr_we_clocks got=%0d exp=3", we_n); end
    checks++;
    if (re_n !== 0) begin failures++; $display("FAIL wr_re_clocks got=%0d exp=0", re_n); end
    checks++;
    if (le_n !== 0) begin failures++; $display("FAIL wr_cpu_le got=%0d exp=0", le_n); end
  endtask

  task automatic test_dma_push();
    logic [23:0] v_dack = '0, v_cs = '0, v_re = '0, v_push = '0, v_pop = '0;
    int pushes = 0;
    DMA_DIR = 1'b1; FIFO_FULL = 1'b0; DMA_EN = 1'b1; DREQ = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      v_dack[i] = !DACK_;
      v_cs[i]   = !SCSI_CS_;
      v_re[i]   = !SCSI_RE_;
      v_push[i] = FIFO_PUSH;
      v_pop[i]  = FIFO_POP;
      if (FIFO_PUSH) pushes++;
      if (pushes == 2) FIFO_FULL = 1'b1;
    end
    checks++;
    if (v_dack !== 24'h0007df) begin failures++; $display("FAIL push_dack got=%h exp=0007df", v_dack); end
    checks++;
    if (v_cs !== 24'h0007df) begin failures++; $display("FAIL push_cs got=%h exp=0007df", v_cs); end
    checks++;
    if (v_re !== 24'h00038e) begin failures++; $display("FAIL push_re got=%h exp=00038e", v_re); end
    checks++;
    if (v_push !== 24'h000208) begin failures++; $display("FAIL push_pulses got=%h exp=000208", v_push); end
    checks++;
    if (v_pop !== 24'h000000) begin failures++; $display("FAIL push_pop got=%h exp=000000", v_pop); end
    checks++;
    if (OWNER !== 1'b0) begin failures++; $display("FAIL push_owner got=%b exp=0", OWNER); end
    DMA_EN = 1'b0; FIFO_FULL = 1'b0;
    tick();
  endtask

  task automatic test_dma_pop();
    logic [15:0] v_dack = '0, v_we = '0, v_pop = '0, v_push = '0;
    DMA_DIR = 1'b0; FIFO_EMPTY = 1'b0; DMA_EN = 1'b1; DREQ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      v_dack[i] = !DACK_;
      v_we[i]   = !SCSI_WE_;
      v_pop[i]  = FIFO_POP;
      v_push[i] = FIFO_PUSH;
      if (i == 1) begin
        DREQ = 1'b0;
        FIFO_EMPTY = 1'b1;
      end
    end
    checks++;
    if (v_dack !== 16'h001f) begin failures++; $display("FAIL pop_dack got=%h exp=001f", v_dack); end
    checks++;
    if (v_we !== 16'h000e) begin failures++; $display("FAIL pop_we got=%h exp=000e", v_we); end
    checks++;
    if (v_pop !== 16'h0001) begin failures++; $display("FAIL pop_pulses got=%h exp=0001", v_pop); end
    checks++;
    if (v_push !== 16'h0000) begin failures++; $display("FAIL pop_push got=%h exp=0000", v_push); end
    DMA_EN = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [1:0] g [0:3];
    int ng = 0;
    logic prev_cs = 1'b1;
    RST = 1'b1;
    tick();
    CPU_REQ = 1'b1; CPU_RW = 1'b1;
    DMA_DIR = 1'b1; FIFO_FULL = 1'b0; DMA_EN = 1'b1; DREQ = 1'b1;
    RST = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (prev_cs && !SCSI_CS_ && ng < 4) begin
        g[ng] = {OWNER, !DACK_};
        ng++;
      end
      prev_cs = SCSI_CS_;
      CPU_REQ = CPU_TERM_;
    end
    checks++;
    if (ng < 3) begin
      failures++; $display("FAIL arb_grant_count got=%0d exp>=3", ng);
    end else begin
      checks++;
      if (g[0] !== 2'b10) begin failures++; $display("FAIL arb_grant0 got=%b exp=10", g[0]); end
      checks++;
      if (g[1] !== 2'b01) begin failures++; $display("FAIL arb_grant1 got=%b exp=01", g[1]); end
      checks++;
      if (g[2] !== 2'b10) begin failures++; $display("FAIL arb_grant2 got=%b exp=10", g[2]); end
    end
    CPU_REQ = 1'b0; DMA_EN = 1'b0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_cpu_abort();
    logic [15:0] v_cs = '0, v_re = '0, v_term = '0, v_le = '0;
    int re_seen = 0;
    CPU_RW = 1'b1;
    CPU_REQ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      v_cs[i]   = !SCSI_CS_;
      v_re[i]   = !SCSI_RE_;
      v_term[i] = !CPU_TERM_;
      v_le[i]   = CPU_LE;
      if (!SCSI_RE_) re_seen++;
      if (re_seen == 2) CPU_REQ = 1'b0;
    end
    checks++;
    if (v_cs !== 16'h000f) begin failures++; $display("FAIL abort_cs got=%h exp=000f", v_cs); end
    checks++;
    if (v_re !== 16'h0006) begin failures++; $display("FAIL abort_re got=%h exp=0006", v_re); end
    checks++;
    if (v_term !== 16'h0000) begin failures++; $display("FAIL abort_term got=%h exp=0000", v_term); end
    checks++;
    if (v_le !== 16'h0000) begin failures++; $display("FAIL abort_le got=%h exp=0000", v_le); end

    v_cs = '0; v_re = '0;
    CPU_REQ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      v_cs[i] = !SCSI_CS_;
      v_re[i] = !SCSI_RE_;
      CPU_REQ = 1'b0;
    end
    checks++;
    if (v_cs !== 16'h0001) begin failures++; $display("FAIL setup_abort_cs got=%h exp=0001", v_cs); end
    checks++;
    if (v_re !== 16'h0000) begin failures++; $display("FAIL setup_abort_re got=%h exp=0000", v_re); end
  endtask

  task automatic test_reset_mid_dma();
    logic [8:0] o;
    DMA_DIR = 1'b1; FIFO_FULL = 1'b0; DMA_EN = 1'b1; DREQ = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({DACK_, SCSI_RE_} !== 2'b00) begin
      failures++; $display("FAIL rst_mid_pre got=%b exp=00", {DACK_, SCSI_RE_});
    end
    RST = 1'b1;
    #1;
    o = outs();
    checks++;
    if (o !== 9'b111110000) begin failures++; $display("FAIL rst_mid_async got=%b exp=111110000", o); end
    DMA_EN = 1'b0;
    tick();
    checks++;
    if (outs() !== 9'b111110000) begin failures++; $display("FAIL rst_mid_hold got=%b exp=111110000", outs()); end
    RST = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dma_push();
    test_dma_pop();
    test_arbitration();
    test_cpu_abort();
    test_reset_mid_dma();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
